sv_arr_read_port: RTL

//  Read side of a small int array that is written by an assignment-style writer port.

---
 rtl/sv_arr_pkg.sv | 15 +
 rtl/sv_arr_rsp_fifo.sv | 54 +++++
 rtl/sv_arr_read_port.sv | 94 +++++++++
 3 files changed

// File: rtl/sv_arr_pkg.sv
// Shared defaults and response type for the array read port.
// No logic, so latency and backpressure do not apply here.
// Consumers import this package for WIDTH/DEPTH/ADDR_W defaults.
package sv_arr_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 2;

    typedef struct packed {
        logic                 err;
        logic [DEF_WIDTH-1:0] data;
    } rsp_t;

endpackage

// File: rtl/sv_arr_rsp_fifo.sv
// Two-entry response FIFO with occupancy count.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push is dropped only when full without a pop; callers gate on count.
module sv_arr_rsp_fifo
    import sv_arr_pkg::*;
#(
    parameter type T = rsp_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld,
    input  T           push_dat,
    output logic       pop_vld,
    input  logic       pop_rdy,
    output T           pop_dat,
    output logic [1:0] count
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;
    logic pop;
    logic push;

    assign pop_vld = (count != 2'd0);
    assign pop_dat = mem[rd_ptr];
    assign pop     = pop_vld && pop_rdy;
    // A same-cycle pop frees the slot the push lands in.
    assign push    = push_vld && ((count != 2'd2) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sv_arr_read_port.sv
// Small int array with an echoing write port and a valid/ready read port.
// Latency: response valid one cycle after request accept; writes forward to same-cycle reads.
// Backpressure: rd_req_ready drops only when the 2-entry response FIFO is full and not popping.
module sv_arr_read_port
    import sv_arr_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  wr_echo,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [WIDTH-1:0]  rd_rsp_data,
    output logic              rd_rsp_err
);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_w_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_word;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             fwd;
    logic [1:0]       fifo_cnt;
    rsp_w_t           rsp_new;
    rsp_w_t           rsp_head;

    assign wr_in_range  = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range  = ({1'b0, rd_addr} < DEPTH_C);
    assign fwd          = wr_en && wr_in_range && (wr_addr == rd_addr);
    assign rd_req_ready = (fifo_cnt != 2'd2) || rd_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_echo <= '0;
        end else if (wr_en && wr_in_range) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
            wr_echo <= wr_data;
        end
    end

    // Decoded select keeps addresses beyond DEPTH from indexing past the array.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = mem[i];
            end
        end
        rsp_new      = '0;
        rsp_new.err  = !rd_in_range;
        if (rd_in_range) begin
            rsp_new.data = fwd ? wr_data : rd_word;
        end
    end

    sv_arr_rsp_fifo #(
        .T (rsp_w_t)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_req_valid && rd_req_ready),
        .push_dat (rsp_new),
        .pop_vld  (rd_rsp_valid),
        .pop_rdy  (rd_rsp_ready),
        .pop_dat  (rsp_head),
        .count    (fifo_cnt)
    );

    assign rd_rsp_data = rsp_head.data;
    assign rd_rsp_err  = rsp_head.err;

endmodule
